// File: rtl/sr_latch_bank_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
//   Shared definitions for the sr_latch_bank family. The package provides:
//     - the S&R collision-resolution mode codes
//     - sr_next() : resolves the next state of one channel from S, R and
//                   the current Q
//     - sr_cw()   : width of the lockout counter for a given lockout length
//   It is imported by sr_cell and sr_latch_bank.
// ---------------------------------------------------------------------------
package sr_pkg;

  // What to do when S and R are both sampled high.
  localparam int SR_MODE_RST_DOM = 0;  // reset wins
  localparam int SR_MODE_SET_DOM = 1;  // set wins
  localparam int SR_MODE_TOGGLE  = 2;  // invert current state
  localparam int SR_MODE_HOLD    = 3;  // keep current state

  localparam int SR_N_MAX = 32;

  typedef enum logic [1:0] {
    SR_REQ_NONE  = 2'b00,
    SR_REQ_RESET = 2'b01,
    SR_REQ_SET   = 2'b10,
    SR_REQ_BOTH  = 2'b11
  } sr_req_e;

  // Next state of one channel ignoring lockout and clear.
  function automatic logic sr_next(input int mode, input logic s,
                                   input logic r, input logic q);
    logic nxt;
    nxt = q;
    case (sr_req_e'({s, r}))
      SR_REQ_SET:   nxt = 1'b1;
      SR_REQ_RESET: nxt = 1'b0;
      SR_REQ_NONE:  nxt = q;
      SR_REQ_BOTH: begin
        case (mode)
          SR_MODE_RST_DOM: nxt = 1'b0;
          SR_MODE_SET_DOM: nxt = 1'b1;
          SR_MODE_TOGGLE:  nxt = ~q;
          default:         nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

  // Lockout counter width; at least one bit so the counter always exists.
  function automatic int sr_cw(input int lock_cycles);
    int w;
    w = $clog2(lock_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sr_latch_bank_if.sv
// ---------------------------------------------------------------------------
// sr_latch_bank_if
//   Request/status bundle of an sr_latch_bank instance.
//   Signals (all N wide unless noted):
//     s, r      set / reset requests (level, sampled on the clock)
//     clr       1 bit, synchronous clear of every channel
//     q, qn     registered state and its complement
//     changed   one-cycle pulse when q[i] takes a new value
//     busy      channel i is inside its lockout window
//     conflict  sticky: s[i]&r[i] was sampled high
//   Modports: master drives requests, slave (the bank) drives status.
// ---------------------------------------------------------------------------
interface sr_latch_bank_if #(
  parameter int N = 4
);
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic         clr;
  logic [N-1:0] q;
  logic [N-1:0] qn;
  logic [N-1:0] changed;
  logic [N-1:0] busy;
  logic [N-1:0] conflict;

  modport master (
    output s, r, clr,
    input  q, qn, changed, busy, conflict
  );

  modport slave (
    input  s, r, clr,
    output q, qn, changed, busy, conflict
  );
endinterface

// File: rtl/sr_latch_bank_cell.sv
// ---------------------------------------------------------------------------
// sr_cell
//   One channel of the SR bank: state bit, lockout counter and sticky
//   conflict flag.
//   Ports:
//     i_clk       rising-edge clock
//     i_rst_n     asynchronous active-low reset
//     i_s, i_r    set / reset request (already synchronised if required)
//     i_clr       synchronous clear, highest priority
//     o_q, o_qn   registered state and complement
//     o_changed   one-cycle pulse on a state change
//     o_busy      lockout counter non-zero
//     o_conflict  sticky S&R flag
// ---------------------------------------------------------------------------
module sr_cell
  import sr_pkg::*;
#(
  parameter int   MODE        = SR_MODE_RST_DOM,
  parameter int   LOCK_CYCLES = 0,
  parameter logic INIT_Q      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_s,
  input  logic i_r,
  input  logic i_clr,
  output logic o_q,
  output logic o_qn,
  output logic o_changed,
  output logic o_busy,
  output logic o_conflict
);

  localparam int            CW        = sr_cw(LOCK_CYCLES);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES);

  logic          r_q;
  logic          r_qn;
  logic          r_changed;
  logic          r_conflict;
  logic [CW-1:0] r_cnt;

  logic w_locked;
  logic w_next;

  assign w_locked = (r_cnt != '0);
  assign w_next   = sr_next(MODE, i_s, i_r, r_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q        <= INIT_Q;
      r_qn       <= ~INIT_Q;
      r_changed  <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else if (i_clr) begin
      // Clear restores the initial value silently: no CHANGED pulse.
      r_q        <= INIT_Q;
      r_qn       <= ~INIT_Q;
      r_changed  <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // Collisions are recorded even while the channel ignores requests.
      if (i_s && i_r) begin
        r_conflict <= 1'b1;
      end
      if (w_locked) begin
        r_cnt     <= r_cnt - CW'(1);
        r_changed <= 1'b0;
      end else if (w_next != r_q) begin
        r_q       <= w_next;
        r_qn      <= ~w_next;
        r_changed <= 1'b1;
        r_cnt     <= LOCK_LOAD;
      end else begin
        r_changed <= 1'b0;
      end
    end
  end

  assign o_q        = r_q;
  assign o_qn       = r_qn;
  assign o_changed  = r_changed;
  assign o_busy     = w_locked;
  assign o_conflict = r_conflict;

endmodule

// File: rtl/sr_latch_bank.sv
// ---------------------------------------------------------------------------
// sr_latch_bank
//   N independent clocked set/reset channels with selectable S&R resolution,
//   per-channel lockout after every state change and sticky collision flags.
//   Ports:
//     i_clk     rising-edge clock
//     i_rst_n   asynchronous active-low reset
//     bus       sr_latch_bank_if.slave (s, r, clr in; q, qn, changed,
//               busy, conflict out)
//   Parameters: N (1..32), MODE (sr_pkg SR_MODE_*), LOCK_CYCLES, INIT_Q.
//   Optional build macro SR_LATCH_BANK_SYNC_EN: s and r pass through a
//   two-flop synchroniser before any channel logic (3-cycle input-to-q
//   latency); clr is never synchronised. Without the macro s/r are used
//   directly (1-cycle latency).
// ---------------------------------------------------------------------------
module sr_latch_bank
  import sr_pkg::*;
#(
  parameter int           N           = 4,
  parameter int           MODE        = SR_MODE_RST_DOM,
  parameter int           LOCK_CYCLES = 0,
  parameter logic [N-1:0] INIT_Q      = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  sr_latch_bank_if.slave  bus
);

  logic [N-1:0] w_s;
  logic [N-1:0] w_r;
  logic [N-1:0] w_q;
  logic [N-1:0] w_qn;
  logic [N-1:0] w_changed;
  logic [N-1:0] w_busy;
  logic [N-1:0] w_conflict;

  genvar gi;

`ifdef SR_LATCH_BANK_SYNC_EN
  // Two-flop synchronisers; CONFLICT is judged on the synchronised pair so
  // it tracks exactly what the state logic saw.
  generate
    for (gi = 0; gi < N; gi++) begin : g_sync
      logic [1:0] r_s_sync;
      logic [1:0] r_r_sync;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_s_sync <= 2'b00;
          r_r_sync <= 2'b00;
        end else begin
          r_s_sync <= {r_s_sync[0], bus.s[gi]};
          r_r_sync <= {r_r_sync[0], bus.r[gi]};
        end
      end

      assign w_s[gi] = r_s_sync[1];
      assign w_r[gi] = r_r_sync[1];
    end
  endgenerate
`else
  assign w_s = bus.s;
  assign w_r = bus.r;
`endif

  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      sr_cell #(
        .MODE        (MODE),
        .LOCK_CYCLES (LOCK_CYCLES),
        .INIT_Q      (INIT_Q[gi])
      ) u_cell (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_s        (w_s[gi]),
        .i_r        (w_r[gi]),
        .i_clr      (bus.clr),
        .o_q        (w_q[gi]),
        .o_qn       (w_qn[gi]),
        .o_changed  (w_changed[gi]),
        .o_busy     (w_busy[gi]),
        .o_conflict (w_conflict[gi])
      );
    end
  endgenerate

  assign bus.q        = w_q;
  assign bus.qn       = w_qn;
  assign bus.changed  = w_changed;
  assign bus.busy     = w_busy;
  assign bus.conflict = w_conflict;

endmodule

// File: tb/tb_sr_latch_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_bank
//   Four sr_latch_bank instances (one per MODE, different lockout lengths
//   and initial values) share the same S/R/CLR stimulus. A behavioural
//   model tracks, per channel, the state, the sticky conflict flag and the
//   edge number of the last state change; lockout and BUSY are derived
//   from the distance to that edge.
// ---------------------------------------------------------------------------
module tb_sr_latch_bank;

  localparam int N = 4;
  localparam int ND = 4;

  localparam int       MODE_C [ND] = '{0, 1, 2, 3};
  localparam int       LOCK_C [ND] = '{0, 3, 1, 2};
  localparam logic [3:0] INIT_C [ND] = '{4'b0000, 4'b1010, 4'b0000, 4'b0011};

  logic clk;
  logic rst_n;
  logic [N-1:0] s_drv;
  logic [N-1:0] r_drv;
  logic         clr_drv;

  int checks = 0;
  int errors = 0;

  sr_latch_bank_if #(.N(N)) if0 ();
  sr_latch_bank_if #(.N(N)) if1 ();
  sr_latch_bank_if #(.N(N)) if2 ();
  sr_latch_bank_if #(.N(N)) if3 ();

  assign if0.s = s_drv; assign if0.r = r_drv; assign if0.clr = clr_drv;
  assign if1.s = s_drv; assign if1.r = r_drv; assign if1.clr = clr_drv;
  assign if2.s = s_drv; assign if2.r = r_drv; assign if2.clr = clr_drv;
  assign if3.s = s_drv; assign if3.r = r_drv; assign if3.clr = clr_drv;

  sr_latch_bank #(.N(N), .MODE(MODE_C[0]), .LOCK_CYCLES(LOCK_C[0]), .INIT_Q(INIT_C[0]))
    dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  sr_latch_bank #(.N(N), .MODE(MODE_C[1]), .LOCK_CYCLES(LOCK_C[1]), .INIT_Q(INIT_C[1]))
    dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  sr_latch_bank #(.N(N), .MODE(MODE_C[2]), .LOCK_CYCLES(LOCK_C[2]), .INIT_Q(INIT_C[2]))
    dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
  sr_latch_bank #(.N(N), .MODE(MODE_C[3]), .LOCK_CYCLES(LOCK_C[3]), .INIT_Q(INIT_C[3]))
    dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));

  logic [N-1:0] obs_q [ND];
  logic [N-1:0] obs_qn [ND];
  logic [N-1:0] obs_chg [ND];
  logic [N-1:0] obs_busy [ND];
  logic [N-1:0] obs_conf [ND];

  assign obs_q[0] = if0.q; assign obs_qn[0] = if0.qn; assign obs_chg[0] = if0.changed;
  assign obs_busy[0] = if0.busy; assign obs_conf[0] = if0.conflict;
  assign obs_q[1] = if1.q; assign obs_qn[1] = if1.qn; assign obs_chg[1] = if1.changed;
  assign obs_busy[1] = if1.busy; assign obs_conf[1] = if1.conflict;
  assign obs_q[2] = if2.q; assign obs_qn[2] = if2.qn; assign obs_chg[2] = if2.changed;
  assign obs_busy[2] = if2.busy; assign obs_conf[2] = if2.conflict;
  assign obs_q[3] = if3.q; assign obs_qn[3] = if3.qn; assign obs_chg[3] = if3.changed;
  assign obs_busy[3] = if3.busy; assign obs_conf[3] = if3.conflict;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [N-1:0] m_q [ND];
  logic [N-1:0] m_chg [ND];
  logic [N-1:0] m_conf [ND];
  int           m_last [ND][N];   // edge number of the most recent change
  int           edge_no;
  logic [N-1:0] s_p1, s_p2, r_p1, r_p2;  // input delay line when synchronised

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_q[d] = INIT_C[d];
      m_chg[d] = '0;
      m_conf[d] = '0;
      for (int i = 0; i < N; i++) m_last[d][i] = -1000;
    end
    s_p1 = '0; s_p2 = '0; r_p1 = '0; r_p2 = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] s_in, input logic [N-1:0] r_in,
                            input logic clr_in);
    logic [N-1:0] se, re;
    logic nxt;
`ifdef SR_LATCH_BANK_SYNC_EN
    se = s_p2; re = r_p2;
    s_p2 = s_p1; r_p2 = r_p1;
    s_p1 = s_in; r_p1 = r_in;
`else
    se = s_in; re = r_in;
`endif
    edge_no++;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < N; i++) begin
        if (clr_in) begin
          m_q[d][i] = INIT_C[d][i];
          m_chg[d][i] = 1'b0;
          m_conf[d][i] = 1'b0;
          m_last[d][i] = -1000;
        end else begin
          if (se[i] && re[i]) m_conf[d][i] = 1'b1;
          if (edge_no <= m_last[d][i] + LOCK_C[d]) begin
            m_chg[d][i] = 1'b0;   // inside the lockout window
          end else begin
            if (se[i] && !re[i]) nxt = 1'b1;
            else if (!se[i] && re[i]) nxt = 1'b0;
            else if (!se[i]) nxt = m_q[d][i];
            else if (MODE_C[d] == 0) nxt = 1'b0;
            else if (MODE_C[d] == 1) nxt = 1'b1;
            else if (MODE_C[d] == 2) nxt = ~m_q[d][i];
            else nxt = m_q[d][i];
            if (nxt != m_q[d][i]) begin
              m_q[d][i] = nxt;
              m_chg[d][i] = 1'b1;
              m_last[d][i] = edge_no;
            end else begin
              m_chg[d][i] = 1'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input int d, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d edge=%0d observed=%b expected=%b", tag, d, edge_no, got, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_busy;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < N; i++)
        exp_busy[i] = (edge_no - m_last[d][i]) < LOCK_C[d];
      check("q", d, obs_q[d], m_q[d]);
      check("qn", d, obs_qn[d], ~m_q[d]);
      check("changed", d, obs_chg[d], m_chg[d]);
      check("busy", d, obs_busy[d], exp_busy);
      check("conflict", d, obs_conf[d], m_conf[d]);
    end
  endtask

  // Drive one sample, let one rising edge take it, then compare.
  task automatic step(input logic [N-1:0] s_v, input logic [N-1:0] r_v, input logic c_v);
    s_drv = s_v; r_drv = r_v; clr_drv = c_v;
    @(posedge clk);
    model_edge(s_v, r_v, c_v);
    #1;
    check_all();
  endtask

  // Assert reset between edges and compare before any edge can occur.
  task automatic do_reset();
    rst_n = 1'b0;
    s_drv = '0; r_drv = '0; clr_drv = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int cycles);
    logic [N-1:0] sv, rv;
    logic cv;
    for (int k = 0; k < cycles; k++) begin
      sv = N'($urandom & $urandom & $urandom);
      rv = N'($urandom & $urandom & $urandom);
      if ((k % 64) < 6) begin
        sv = '1; rv = '1;      // sustained collisions exercise toggle/lockout
      end
      cv = ($urandom_range(0, 19) == 0);
      step(sv, rv, cv);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    s_drv = '0; r_drv = '0; clr_drv = 1'b0;
    edge_no = 0;
    #2;
    do_reset();

    // basic set / reset on channel 0
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, 1'b0);

    // simultaneous S&R on channel 2 (q[2]=0 in every instance)
    step(4'b0100, 4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);

    // lockout: set channel 0, then hold reset
    step(4'b0001, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0000, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // sustained S&R on channel 3 (toggle every L+1 cycles in MODE2)
    for (int k = 0; k < 9; k++) step(4'b1000, 4'b1000, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);

    // clear during lockout
    step(4'b1111, 4'b0000, 1'b0);
    step(4'b0000, 4'b1111, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    random_run(400);

    // asynchronous reset while channels are locked out
    step(4'b0101, 4'b1010, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    do_reset();
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 1'b0);

    random_run(150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
